param_loader: RTL
=================

// Module: param_loader
// PURPOSE
//   Host-side parameter streamer for the BNN neuron chain. Accepts parameter bytes
//   over a valid/ready interface, serialises them MSB-first onto the chain's serial
//   parameter input, and asserts setup exactly on the cycles a bit is shifted.
//   It sits between the chip input pins and the first neuron's param_in.
//   The neurons themselves are daisy-chained param_out -> param_in.
// PARAMETERS
//   CHAIN_BITS  88  total bits in the chain (sum of INPUTS+BIAS_BITS over all neurons), >=1
//   CNT_BITS    $clog2(CHAIN_BITS+1)  localparam, width of the remaining-bit counter
// PORTS
//   clk           in   1  system clock, all state on posedge
//   rst_n         in   1  asynchronous, active-low reset
//   start         in   1  begin a load; sampled only in IDLE
//   data_in       in   8  parameter byte; bit 7 is shifted first
//   data_valid    in   1  data_in holds a valid byte
//   data_ready    out  1  loader can take a byte this cycle
//   setup         out  1  chain shift enable; drives every neuron's setup
//   param_serial  out  1  serial bit to the first neuron's param_in
//   busy          out  1  high in LOAD and SHIFT
//   done          out  1  one-cycle pulse when the last chain bit has been shifted
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE; setup=0, param_serial=0, data_ready=0, busy=0,
//     done=0; remaining counter=0, byte buffer=0. Reset mid-load leaves the chain partly
//     written; the host must re-run a full load.
//   States: IDLE -> LOAD -> SHIFT -> (LOAD | DONE) -> IDLE.
//   IDLE: start=1 -> LOAD, remaining<=CHAIN_BITS. data_valid ignored (data_ready=0).
//   LOAD: data_ready=1 (combinational from state). On data_valid&&data_ready: latch
//     data_in into the buffer, bit index<=7, go to SHIFT. No stall limit; setup=0 while waiting.
//   SHIFT: registered setup=1 and param_serial=buffer[index] for one cycle per bit.
//     Each cycle: remaining-=1, index-=1.
//     After the bit with index 0 and remaining>0 -> LOAD.
//     When remaining hits 0 -> DONE, even mid-byte; unused low bits of the last byte are discarded.
//   DONE: done=1 for exactly one cycle, setup=0, then IDLE.
//   Latency: a byte accepted at cycle N drives bits 7..0 on cycles N+1..N+8.
//     Throughput is 9 cycles per full byte.
//   setup is never high outside SHIFT, so neurons hold their parameters at all other times.
//   Bit placement: the first bit sent ends deepest in the chain (bias MSB of last neuron).
//     The last bit sent lands in weights[0] of the first neuron.
//   start while busy/DONE: ignored. data_valid outside LOAD: not accepted, byte held by host.
//   Bytes required per load = ceil(CHAIN_BITS/8). Counter arithmetic is unsigned, CNT_BITS wide.
//     It never underflows: the SHIFT exit is taken at remaining==1.
// TESTING
//   1 Reset: assert rst_n=0 mid-SHIFT -> setup, param_serial, busy, data_ready, done all 0
//     without a clock edge. After release the block is in IDLE.
//   2 CHAIN_BITS=11, one neuron model (INPUTS=8, BIAS_BITS=3): start, bytes 0xA5, 0xE0.
//     Required: setup high for exactly 11 cycles, serial 1,0,1,0,0,1,0,1,1,1,1.
//     done pulses the cycle after the last bit; neuron holds bias=3'b101, weights=8'h2F.
//   3 Stalls: CHAIN_BITS=16, host holds data_valid low 5 cycles between bytes 0x3C, 0x81.
//     Required: setup low during the gap, data_ready high throughout.
//     Serial stream is 00111100 10000001 and done pulses once.
//   4 Ignored inputs: data_valid=1 in IDLE -> data_ready=0, no shift.
//     start pulsed during SHIFT -> remaining unaffected, a single done pulse.
//   5 Default CHAIN_BITS=88, 11 back-to-back bytes with data_valid always high.
//     Required: setup high for exactly 88 cycles, done 99 cycles after the first accept.
//     8-neuron chain model matches the expected weights/bias.
//   6 Partial last byte: CHAIN_BITS=13, bytes 0xFF, 0xA7.
//     Required: exactly 13 setup cycles; last five bits 1,0,1,0,0; low bits 111 of 0xA7 never driven.

Source files
------------

// File: rtl/param_loader.sv
// Host-side parameter streamer: takes bytes over valid/ready and shifts them
// MSB-first into the neuron chain, raising setup only on shift cycles.
module param_loader #(
    parameter int unsigned CHAIN_BITS = 88
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       setup,
    output logic       param_serial,
    output logic       busy,
    output logic       done
);

    localparam int unsigned CNT_BITS = $clog2(CHAIN_BITS + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    logic [CNT_BITS-1:0] r_rem;
    logic [7:0]          r_buf;
    logic [2:0]          r_idx;
    logic                r_setup;
    logic                r_serial;
    logic                r_busy;
    logic                r_done;

    logic                w_accept;
    logic [2:0]          w_idx_next;
    logic                w_last_bit;

    // Ready is a direct decode of the LOAD state so a byte is taken the cycle it is offered.
    assign data_ready = (r_state == S_LOAD);
    assign w_accept   = data_valid && data_ready;
    assign w_idx_next = r_idx - 3'd1;
    // Exit on remaining==1 so the counter never wraps below zero.
    assign w_last_bit = (r_rem == CNT_BITS'(1));

    assign setup        = r_setup;
    assign param_serial = r_serial;
    assign busy         = r_busy;
    assign done         = r_done;

    // Load/shift sequencer with registered chain-facing outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_rem    <= '0;
            r_buf    <= '0;
            r_idx    <= '0;
            r_setup  <= 1'b0;
            r_serial <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state <= S_LOAD;
                        r_rem   <= CNT_BITS'(CHAIN_BITS);
                        r_busy  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        r_buf    <= data_in;
                        r_idx    <= 3'd7;
                        r_setup  <= 1'b1;
                        r_serial <= data_in[7];
                        r_state  <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_rem <= r_rem - CNT_BITS'(1);
                    if (w_last_bit) begin
                        // Chain full: any unsent low bits of this byte are dropped.
                        r_setup  <= 1'b0;
                        r_serial <= 1'b0;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end else if (r_idx == 3'd0) begin
                        r_setup  <= 1'b0;
                        r_serial <= 1'b0;
                        r_state  <= S_LOAD;
                    end else begin
                        r_idx    <= w_idx_next;
                        r_serial <= r_buf[w_idx_next];
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
